// File: rtl/demux_dispatcher.sv
// Header-framed byte stream dispatcher feeding a 4-lane demux through one output register.
// Optional lane masking with packet drop counting: DEMUX_DISPATCH_LANE_MASK_EN.
module demux_dispatcher #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        lane_ready,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        sel,
  output logic              dout_valid,
  output logic              busy,
  output logic              pkt_done
`ifdef DEMUX_DISPATCH_LANE_MASK_EN
  ,
  input  logic [3:0]        lane_en,
  output logic [7:0]        drop_cnt
`endif
);

  // state   | meaning
  // IDLE    | next input byte is a header
  // PAYLOAD | counting down payload bytes of the current packet
  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       pend_sel;
  logic             out_last;
  logic             fire, accept, hdr_acc, pay_acc, load;
  logic             hdr_keep, pkt_drop;

  assign fire     = dout_valid && lane_ready[sel];
  // A dropped packet never touches the output register, so its bytes are always taken.
  assign in_ready = (state == PAYLOAD && pkt_drop) ? 1'b1 : (!dout_valid || fire);
  assign accept   = in_valid && in_ready;
  assign hdr_acc  = accept && (state == IDLE);
  assign pay_acc  = accept && (state == PAYLOAD);
  assign load     = pay_acc && !pkt_drop;
  assign busy     = (state == PAYLOAD) || dout_valid;

`ifdef DEMUX_DISPATCH_LANE_MASK_EN
  assign hdr_keep = lane_en[in_data[1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_drop <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (hdr_acc) begin
      pkt_drop <= !hdr_keep;
      if (!hdr_keep && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign hdr_keep = 1'b1;
  assign pkt_drop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (hdr_acc) begin
          cnt_nxt   = CNT_W'(in_data[7:2]) + CNT_W'(1);
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pay_acc) begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Header accept implies the output register is empty or emptying, so sel may move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_sel   <= 2'd0;
      sel        <= 2'd0;
      dout       <= '0;
      dout_valid <= 1'b0;
      out_last   <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      if (hdr_acc)
        pend_sel <= in_data[1:0];
      if (hdr_acc && hdr_keep)
        sel <= in_data[1:0];
      else if (load)
        sel <= pend_sel;
      if (load) begin
        dout       <= in_data;
        dout_valid <= 1'b1;
        out_last   <= (cnt == CNT_W'(1));
      end else if (fire) begin
        dout       <= '0;
        dout_valid <= 1'b0;
        out_last   <= 1'b0;
      end
      pkt_done <= fire && out_last;
    end
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed self-checking bench for demux_dispatcher.
// Build with DEMUX_DISPATCH_LANE_MASK_EN to include the lane mask scenario.
module tb_demux_dispatcher;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] lane_ready = 4'hF;
  logic [7:0] dout;
  logic [1:0] sel;
  logic       dout_valid, busy, pkt_done;
`ifdef DEMUX_DISPATCH_LANE_MASK_EN
  logic [3:0] lane_en = 4'hF;
  logic [7:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  demux_dispatcher #(.DATA_W(8), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .lane_ready(lane_ready), .dout(dout), .sel(sel),
    .dout_valid(dout_valid), .busy(busy), .pkt_done(pkt_done)
`ifdef DEMUX_DISPATCH_LANE_MASK_EN
    , .lane_en(lane_en), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Observed vector layout: {dout_valid, dout, sel, pkt_done, busy}
  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    lane_ready = 4'hF;
    #2;
    checks++;
    if ({dout_valid, dout, sel, pkt_done, busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {dout_valid, dout, sel, pkt_done, busy});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    step;
    step;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0]  stim [4];
    logic [12:0] exp  [6];
    stim = '{8'h09, 8'hA1, 8'hA2, 8'hA3};
    exp  = '{{1'b0, 8'h00, 2'd1, 1'b0, 1'b1},
             {1'b1, 8'hA1, 2'd1, 1'b0, 1'b1},
             {1'b1, 8'hA2, 2'd1, 1'b0, 1'b1},
             {1'b1, 8'hA3, 2'd1, 1'b0, 1'b1},
             {1'b0, 8'h00, 2'd1, 1'b1, 1'b0},
             {1'b0, 8'h00, 2'd1, 1'b0, 1'b0}};
    lane_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_data  = (i < 4) ? stim[i] : 8'h00;
      step;
      checks++;
      if ({dout_valid, dout, sel, pkt_done, busy} !== exp[i]) begin
        errors++;
        $display("FAIL basic_cycle%0d got=%h want=%h", i, {dout_valid, dout, sel, pkt_done, busy}, exp[i]);
      end
    end
  endtask

  task automatic test_stall;
    lane_ready = 4'b1011;
    in_valid = 1'b1;
    in_data  = 8'h02;
    step;
    in_data  = 8'h55;
    step;
    in_valid = 1'b1;
    in_data  = 8'h0C;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({dout_valid, dout, sel, in_ready} !== {1'b1, 8'h55, 2'd2, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d got=%h want=%h", i, {dout_valid, dout, sel, in_ready}, {1'b1, 8'h55, 2'd2, 1'b0});
      end
      step;
    end
    in_valid = 1'b0;
    lane_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready got=%b want=1", in_ready);
    end
    step;
    checks++;
    if ({dout_valid, dout, sel, pkt_done, busy} !== {1'b0, 8'h00, 2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stall_release got=%h want=%h", {dout_valid, dout, sel, pkt_done, busy}, {1'b0, 8'h00, 2'd2, 1'b1, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  stim [4];
    logic [12:0] exp  [6];
    stim = '{8'h03, 8'hFF, 8'h00, 8'h11};
    exp  = '{{1'b0, 8'h00, 2'd3, 1'b0, 1'b1},
             {1'b1, 8'hFF, 2'd3, 1'b0, 1'b1},
             {1'b0, 8'h00, 2'd0, 1'b1, 1'b1},
             {1'b1, 8'h11, 2'd0, 1'b0, 1'b1},
             {1'b0, 8'h00, 2'd0, 1'b1, 1'b0},
             {1'b0, 8'h00, 2'd0, 1'b0, 1'b0}};
    lane_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_data  = (i < 4) ? stim[i] : 8'h00;
      step;
      checks++;
      if ({dout_valid, dout, sel, pkt_done, busy} !== exp[i]) begin
        errors++;
        $display("FAIL b2b_cycle%0d got=%h want=%h", i, {dout_valid, dout, sel, pkt_done, busy}, exp[i]);
      end
    end
  endtask

  task automatic test_max_len;
    logic [12:0] want;
    lane_ready = 4'hF;
    for (int i = 0; i < 68; i++) begin
      in_valid = (i < 67);
      if (i == 0)       in_data = 8'hFC;
      else if (i <= 64) in_data = 8'(i - 1);
      else if (i == 65) in_data = 8'h01;
      else              in_data = 8'hEE;
      step;
      if (i == 0)       want = {1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
      else if (i <= 64) want = {1'b1, 8'(i - 1), 2'd0, 1'b0, 1'b1};
      else if (i == 65) want = {1'b0, 8'h00, 2'd1, 1'b1, 1'b1};
      else if (i == 66) want = {1'b1, 8'hEE, 2'd1, 1'b0, 1'b1};
      else              want = {1'b0, 8'h00, 2'd1, 1'b1, 1'b0};
      checks++;
      if ({dout_valid, dout, sel, pkt_done, busy} !== want) begin
        errors++;
        $display("FAIL maxlen_cycle%0d got=%h want=%h", i, {dout_valid, dout, sel, pkt_done, busy}, want);
      end
    end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_reset_mid_packet;
    logic [7:0]  stim [3];
    logic [12:0] exp  [4];
    lane_ready = 4'hF;
    stim = '{8'h0D, 8'hB1, 8'hB2};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      step;
    end
    in_valid = 1'b0;
    checks++;
    if ({dout_valid, dout} !== {1'b1, 8'hB2}) begin
      errors++;
      $display("FAIL midrst_pre got=%h want=%h", {dout_valid, dout}, {1'b1, 8'hB2});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout_valid, dout, sel, pkt_done, busy} !== 13'd0) begin
      errors++;
      $display("FAIL midrst_outputs got=%h want=0", {dout_valid, dout, sel, pkt_done, busy});
    end
    step;
    rst_n = 1'b1;
    stim = '{8'h04, 8'hC1, 8'hC2};
    exp  = '{{1'b0, 8'h00, 2'd0, 1'b0, 1'b1},
             {1'b1, 8'hC1, 2'd0, 1'b0, 1'b1},
             {1'b1, 8'hC2, 2'd0, 1'b0, 1'b1},
             {1'b0, 8'h00, 2'd0, 1'b1, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3);
      in_data  = (i < 3) ? stim[i] : 8'h00;
      step;
      checks++;
      if ({dout_valid, dout, sel, pkt_done, busy} !== exp[i]) begin
        errors++;
        $display("FAIL midrst_after%0d got=%h want=%h", i, {dout_valid, dout, sel, pkt_done, busy}, exp[i]);
      end
    end
    step;
  endtask

`ifdef DEMUX_DISPATCH_LANE_MASK_EN
  task automatic test_lane_mask;
    logic [7:0]  stim [5];
    logic [12:0] exp  [6];
    lane_en = 4'b1101;
    lane_ready = 4'hF;
    stim = '{8'h05, 8'hD1, 8'hD2, 8'h00, 8'h77};
    exp  = '{{1'b0, 8'h00, 2'd0, 1'b0, 1'b1},
             {1'b0, 8'h00, 2'd0, 1'b0, 1'b1},
             {1'b0, 8'h00, 2'd0, 1'b0, 1'b0},
             {1'b0, 8'h00, 2'd0, 1'b0, 1'b1},
             {1'b1, 8'h77, 2'd0, 1'b0, 1'b1},
             {1'b0, 8'h00, 2'd0, 1'b1, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 5);
      in_data  = (i < 5) ? stim[i] : 8'h00;
      #1;
      if (i < 5) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL mask_ready%0d got=%b want=1", i, in_ready);
        end
      end
      step;
      checks++;
      if ({dout_valid, dout, sel, pkt_done, busy} !== exp[i]) begin
        errors++;
        $display("FAIL mask_cycle%0d got=%h want=%h", i, {dout_valid, dout, sel, pkt_done, busy}, exp[i]);
      end
    end
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL mask_drop_cnt got=%0d want=1", drop_cnt);
    end
    lane_en = 4'hF;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_back_to_back;
    test_max_len;
    test_reset_mid_packet;
`ifdef DEMUX_DISPATCH_LANE_MASK_EN
    test_lane_mask;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_dispatcher.md
Name: demux_dispatcher

Overview:
- Upstream feeder for the 4-lane byte demultiplexer: accepts a header-framed byte stream over a valid/ready handshake.
- Decodes each packet header into a lane select, then drives payload bytes plus a stable 2-bit select to the demux.
- Back-pressure comes from per-lane ready signals.
- A single output register decouples input from output timing.

Parameters:
- DATA_W, 8, payload/data width; header fields occupy bits [7:0]; must be >= 8.
- CNT_W, 7, width of the remaining-byte counter; must hold 64.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_W  input byte (header or payload)
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- lane_ready  input  4  per-lane sink ready, indexed by lane number
- dout  output  DATA_W  data to demux IN
- sel  output  2  lane select to demux Sel
- dout_valid  output  1  dout/sel hold a byte for lane sel
- busy  output  1  high while in PAYLOAD state or dout_valid high
- pkt_done  output  1  one-cycle pulse when the last payload byte of a packet transfers out

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; dout=0, sel=0, dout_valid=0, busy=0, pkt_done=0; counter=0.
  - Reset mid-packet abandons the packet; no bytes are emitted after release.
- Accept and transfer:
  - Input accept: in_valid && in_ready.
  - Output transfer (fire): dout_valid && lane_ready[sel].
- Header format: lane = in_data[1:0]; length = in_data[7:2] + 1 payload bytes (1..64). The header is consumed, never forwarded.
- State IDLE:
  - in_ready = !dout_valid || fire.
  - On accept, latch lane into a pending-select register and counter = length; go to PAYLOAD.
  - sel updates to the new lane only when dout_valid is 0 or drops on the same edge. sel never changes while dout_valid=1.
- State PAYLOAD:
  - in_ready = !dout_valid || fire.
  - On accept: dout <= in_data; sel <= latched lane; dout_valid <= 1; counter decrements.
  - On accepting the byte where counter == 1, go to IDLE.
- Output register rules:
  - Fire without a new accept: dout_valid <= 0 and dout <= 0. dout is 0 whenever dout_valid=0, so demux lanes idle at 0x00.
  - Fire and accept in the same cycle: the new byte replaces the old one. Full throughput is 1 byte/cycle.
- Latency: payload byte accepted at edge N appears on dout after edge N (registered, 1 cycle). Header costs 1 input cycle with no output.
- Stalling:
  - lane_ready[sel]=0 holds dout, sel and dout_valid stable indefinitely; in_ready=0.
  - Ready on other lanes is ignored.
- pkt_done asserts for 1 cycle on the fire of the last byte of a packet. It is registered, asserting the cycle after that fire.
- Back-to-back packets:
  - A header may be accepted in the same cycle the previous packet's last byte fires.
  - The next packet's first payload byte can appear 2 cycles after the previous last byte was accepted.
- in_valid=0 mid-packet: hold state and counter; no timeout.

Optional Feature:
- Macro DEMUX_DISPATCH_LANE_MASK_EN.
- Defined:
  - Adds input lane_en[3:0].
  - A header whose lane has lane_en[lane]=0 at header accept marks the packet as dropped.
  - Payload bytes are accepted with in_ready=1 (subject to the normal output-register rule only for kept packets) and discarded: no dout_valid, no pkt_done.
  - The state machine returns to IDLE after length bytes.
  - Adds output drop_cnt[7:0]: increments per dropped header, saturates at 255, reset 0.
- Undefined: no lane_en or drop_cnt ports; every packet is forwarded.

Test Plan:
- Reset then header 0x09 (lane 1, length 3), payload 0xA1,0xA2,0xA3, all lane_ready=1:
  - dout/sel=1 show A1,A2,A3 on consecutive cycles.
  - pkt_done pulses once after A3 fires; busy falls.
- Header 0x02 (lane 2, length 1), payload 0x55 with lane_ready[2]=0 for 5 cycles:
  - dout=0x55, sel=2, dout_valid=1 held stable; in_ready=0.
  - lane_ready[0,1,3]=1 have no effect; transfer on the release cycle.
- Back-to-back headers 0x03/0xFF, then 0x00/0x11, streamed with constant in_valid:
  - Lane 3 gets 0xFF, then lane 0 gets 0x11.
  - sel never changes while dout_valid=1; two pkt_done pulses.
- Header 0xFC (lane 0, length 64) with 64 bytes 0..63:
  - All 64 bytes emitted in order; the 65th input byte is treated as a header.
- Assert rst_n=0 after 2 of 4 payload bytes (header 0x0D):
  - Outputs immediately 0, dout_valid=0; after release, the next byte is decoded as a header.
- With DEMUX_DISPATCH_LANE_MASK_EN, lane_en=4'b1101, header 0x05 (lane 1, length 2), then 0x00/0x77:
  - The two lane-1 bytes are swallowed; drop_cnt=1; only 0x77 appears on lane 0.
